// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module : usb_pkg
// Brief  : Shared PID encodings, sequencer states and defaults for usb_xfer_ctrl.
// Rev    : 1.0
// ============================================================================
package usb_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 162;
  localparam int MAX_PKT_DEF        = 64;

  typedef enum logic [2:0] {
    RX_NONE  = 3'd0,
    RX_OUT   = 3'd1,
    RX_IN    = 3'd2,
    RX_DATA0 = 3'd3,
    RX_DATA1 = 3'd4,
    RX_ACK   = 3'd5,
    RX_NAK   = 3'd6,
    RX_STALL = 3'd7
  } rx_pid_t;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_DATA1 = 3'd2,
    TX_ACK   = 3'd3,
    TX_NAK   = 3'd4,
    TX_STALL = 3'd5
  } tx_pid_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OUT_DATA = 2'd1,
    ST_TX_WAIT  = 2'd2,
    ST_IN_ACK   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/usb_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module : usb_timeout_timer
// Brief  : Saturating turnaround counter; expired once TIMEOUT_CYCLES idle clocks elapse.
// Rev    : 1.0
// ============================================================================
module usb_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 162
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != C_LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/usb_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : usb_xfer_ctrl
// Brief  : Endpoint transaction sequencer: token decode, handshake launch, toggles, timeouts.
// Rev    : 1.0
// ============================================================================
module usb_xfer_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int MAX_PKT        = MAX_PKT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     rx_packet,
  input  logic                           rx_data_ready,
  input  logic                           rx_transfer_active,
  input  logic                           rx_error,
  input  logic                           tx_transfer_active,
  input  logic                           tx_error,
  input  logic [$clog2(MAX_PKT+1)-1:0]   buffer_occupancy,
  input  logic                           tx_data_valid,
  input  logic                           stall_en,
  input  logic                           toggle_reset,
  output logic [2:0]                     tx_packet,
  output logic                           tx_start,
  output logic                           rx_store_en,
  output logic                           clear,
  output logic                           xfer_done,
  output logic                           xfer_dir,
  output logic                           xfer_err
);

  localparam logic [2:0] C_TX_RISE_LIMIT = 3'd4;

  state_t     r_state,     w_state;
  tx_pid_t    r_tx_packet, w_tx_packet;
  logic       r_tx_start,  w_tx_start;
  logic       r_store,     w_store;
  logic       r_clear,     w_clear;
  logic       r_done,      w_done;
  logic       r_dir,       w_dir;
  logic       r_err,       w_err;
  logic       r_out_tog,   w_out_tog;
  logic       r_in_tog,    w_in_tog;
  logic [2:0] r_tx_cnt,    w_tx_cnt;
  logic       r_tx_seen,   w_tx_seen;
  logic       r_tx_data,   w_tx_data;
  logic       r_tx_in,     w_tx_in;

  rx_pid_t    w_pid;
  logic       w_is_data;
  logic       w_data_bit;
  logic       w_expired;
  logic       w_timer_clear;
  logic       w_timer_run;

  assign w_pid      = rx_pid_t'(rx_packet);
  assign w_is_data  = (w_pid == RX_DATA0) || (w_pid == RX_DATA1);
  assign w_data_bit = (w_pid == RX_DATA1);

  assign w_timer_clear = (w_state != r_state);
  assign w_timer_run   = ((r_state == ST_OUT_DATA) || (r_state == ST_IN_ACK)) && !rx_transfer_active;

  usb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_timer_clear),
    .run    (w_timer_run),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tx_packet <= TX_NONE;
      r_tx_start  <= 1'b0;
      r_store     <= 1'b0;
      r_clear     <= 1'b0;
      r_done      <= 1'b0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_out_tog   <= 1'b0;
      r_in_tog    <= 1'b0;
      r_tx_cnt    <= 3'd0;
      r_tx_seen   <= 1'b0;
      r_tx_data   <= 1'b0;
      r_tx_in     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tx_packet <= w_tx_packet;
      r_tx_start  <= w_tx_start;
      r_store     <= w_store;
      r_clear     <= w_clear;
      r_done      <= w_done;
      r_dir       <= w_dir;
      r_err       <= w_err;
      r_out_tog   <= w_out_tog;
      r_in_tog    <= w_in_tog;
      r_tx_cnt    <= w_tx_cnt;
      r_tx_seen   <= w_tx_seen;
      r_tx_data   <= w_tx_data;
      r_tx_in     <= w_tx_in;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_tx_packet = r_tx_packet;
    w_tx_start  = 1'b0;
    w_store     = r_store;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    w_dir       = r_dir;
    w_err       = 1'b0;
    w_out_tog   = r_out_tog;
    w_in_tog    = r_in_tog;
    w_tx_cnt    = (r_tx_cnt == C_TX_RISE_LIMIT) ? r_tx_cnt : r_tx_cnt + 3'd1;
    w_tx_seen   = r_tx_seen | tx_transfer_active;
    w_tx_data   = r_tx_data;
    w_tx_in     = r_tx_in;

    unique case (r_state)
      ST_IDLE: begin
        if (rx_data_ready && (w_pid == RX_OUT)) begin
          w_store = (buffer_occupancy == '0) && !stall_en;
          w_state = ST_OUT_DATA;
        end else if (rx_data_ready && (w_pid == RX_IN)) begin
          w_tx_start = 1'b1;
          w_state    = ST_TX_WAIT;
          w_tx_cnt   = 3'd0;
          w_tx_seen  = 1'b0;
          w_tx_in    = 1'b1;
          w_tx_data  = !stall_en && tx_data_valid;
          if (stall_en)           w_tx_packet = TX_STALL;
          else if (tx_data_valid) w_tx_packet = r_in_tog ? TX_DATA1 : TX_DATA0;
          else                    w_tx_packet = TX_NAK;
        end
      end

      ST_OUT_DATA: begin
        if (rx_error) begin
          w_clear = r_store;
          w_err   = 1'b1;
          w_dir   = 1'b0;
          w_store = 1'b0;
          w_state = ST_IDLE;
        end else if (rx_data_ready && w_is_data) begin
          w_store    = 1'b0;
          w_tx_start = 1'b1;
          w_state    = ST_TX_WAIT;
          w_tx_cnt   = 3'd0;
          w_tx_seen  = 1'b0;
          w_tx_in    = 1'b0;
          w_tx_data  = 1'b0;
          if (!r_store) begin
            w_tx_packet = stall_en ? TX_STALL : TX_NAK;
          end else if (w_data_bit == r_out_tog) begin
            w_tx_packet = TX_ACK;
            w_out_tog   = ~r_out_tog;
            w_done      = 1'b1;
            w_dir       = 1'b0;
          end else begin
            // Host missed our ACK and resent; re-ACK and drop the duplicate payload.
            w_tx_packet = TX_ACK;
            w_clear     = 1'b1;
          end
        end else if (w_expired) begin
          w_err   = 1'b1;
          w_dir   = 1'b0;
          w_store = 1'b0;
          w_state = ST_IDLE;
        end
      end

      ST_TX_WAIT: begin
        if (tx_error || (!r_tx_seen && !tx_transfer_active && (r_tx_cnt == C_TX_RISE_LIMIT))) begin
          w_err       = 1'b1;
          w_dir       = r_tx_in;
          w_tx_packet = TX_NONE;
          w_state     = ST_IDLE;
        end else if (r_tx_seen && !tx_transfer_active) begin
          w_tx_packet = TX_NONE;
          w_state     = r_tx_data ? ST_IN_ACK : ST_IDLE;
        end
      end

      ST_IN_ACK: begin
        if (rx_error || (rx_data_ready && (w_pid != RX_ACK)) || (!rx_data_ready && w_expired)) begin
          w_err   = 1'b1;
          w_dir   = 1'b1;
          w_clear = 1'b1;
          w_state = ST_IDLE;
        end else if (rx_data_ready) begin
          w_in_tog = ~r_in_tog;
          w_done   = 1'b1;
          w_dir    = 1'b1;
          w_state  = ST_IDLE;
        end
      end

      default: w_state = ST_IDLE;
    endcase

    if (toggle_reset) begin
      w_out_tog = 1'b0;
      w_in_tog  = 1'b0;
    end
  end

  assign tx_packet   = r_tx_packet;
  assign tx_start    = r_tx_start;
  assign rx_store_en = r_store;
  assign clear       = r_clear;
  assign xfer_done   = r_done;
  assign xfer_dir    = r_dir;
  assign xfer_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_usb_xfer_ctrl
// Brief  : Directed self-checking bench for usb_xfer_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_usb_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_packet = 3'd0;
  logic       rx_data_ready = 1'b0;
  logic       rx_transfer_active = 1'b0;
  logic       rx_error = 1'b0;
  logic       tx_transfer_active = 1'b0;
  logic       tx_error = 1'b0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       tx_data_valid = 1'b0;
  logic       stall_en = 1'b0;
  logic       toggle_reset = 1'b0;
  logic [2:0] tx_packet;
  logic       tx_start;
  logic       rx_store_en;
  logic       clear;
  logic       xfer_done;
  logic       xfer_dir;
  logic       xfer_err;

  int vectors = 0;
  int miscompares = 0;
  int n;

  localparam logic [2:0] P_OUT = 3'd1, P_IN = 3'd2, P_D0 = 3'd3, P_D1 = 3'd4, P_ACK = 3'd5;
  localparam logic [2:0] T_NONE = 3'd0, T_D0 = 3'd1, T_D1 = 3'd2, T_ACK = 3'd3, T_NAK = 3'd4, T_STALL = 3'd5;

  usb_xfer_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .rx_packet         (rx_packet),
    .rx_data_ready     (rx_data_ready),
    .rx_transfer_active(rx_transfer_active),
    .rx_error          (rx_error),
    .tx_transfer_active(tx_transfer_active),
    .tx_error          (tx_error),
    .buffer_occupancy  (buffer_occupancy),
    .tx_data_valid     (tx_data_valid),
    .stall_en          (stall_en),
    .toggle_reset      (toggle_reset),
    .tx_packet         (tx_packet),
    .tx_start          (tx_start),
    .rx_store_en       (rx_store_en),
    .clear             (clear),
    .xfer_done         (xfer_done),
    .xfer_dir          (xfer_dir),
    .xfer_err          (xfer_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pkt(input logic [2:0] pid);
    rx_packet     = pid;
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    rx_packet     = 3'd0;
  endtask

  task automatic tx_complete();
    tx_transfer_active = 1'b1;
    tick();
    tick();
    tx_transfer_active = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, tx_packet, tx_start, rx_store_en, clear, xfer_done, xfer_dir, xfer_err};
  endfunction

  initial begin
    tick();
    tick();
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    tick();

    // OUT + DATA0 with empty FIFO: stored, ACKed, done
    pkt(P_OUT);
    chk("out_store_en", rx_store_en, 1);
    rx_transfer_active = 1'b1;
    tick(); tick(); tick();
    rx_transfer_active = 1'b0;
    pkt(P_D0);
    chk("out_d0_start", tx_start, 1);
    chk("out_d0_pid", tx_packet, T_ACK);
    chk("out_d0_done", xfer_done, 1);
    chk("out_d0_dir", xfer_dir, 0);
    chk("out_d0_store_drop", rx_store_en, 0);
    tx_complete();
    chk("out_d0_release", tx_packet, T_NONE);

    // Duplicate DATA0 while out_toggle = 1
    pkt(P_OUT);
    pkt(P_D0);
    chk("dup_pid", tx_packet, T_ACK);
    chk("dup_clear", clear, 1);
    chk("dup_no_done", xfer_done, 0);
    tx_complete();
    pkt(P_OUT);
    pkt(P_D1);
    chk("d1_after_dup_done", xfer_done, 1);
    chk("d1_after_dup_clear", clear, 0);
    tx_complete();

    // Non-empty FIFO: NAK, then STALL when halted
    buffer_occupancy = 7'd5;
    pkt(P_OUT);
    chk("busy_store_en", rx_store_en, 0);
    pkt(P_D1);
    chk("busy_nak", tx_packet, T_NAK);
    chk("busy_no_clear", clear, 0);
    chk("busy_no_done", xfer_done, 0);
    tx_complete();
    stall_en = 1'b1;
    pkt(P_OUT);
    pkt(P_D1);
    chk("halt_stall", tx_packet, T_STALL);
    tx_complete();
    stall_en = 1'b0;
    buffer_occupancy = 7'd0;

    // IN with data: DATA0, host ACK
    tx_data_valid = 1'b1;
    pkt(P_IN);
    chk("in_start", tx_start, 1);
    chk("in_d0", tx_packet, T_D0);
    tx_complete();
    pkt(P_ACK);
    chk("in_ack_done", xfer_done, 1);
    chk("in_ack_dir", xfer_dir, 1);

    // Next IN uses DATA1, then host stays silent
    pkt(P_IN);
    chk("in_d1", tx_packet, T_D1);
    tx_transfer_active = 1'b1;
    tick(); tick();
    tx_transfer_active = 1'b0;
    tick();
    n = 0;
    while (n < 200 && !xfer_err) begin
      tick();
      n++;
    end
    chk("in_timeout_cycles", n, 163);
    chk("in_timeout_clear", clear, 1);
    chk("in_timeout_dir", xfer_dir, 1);
    tick();
    chk("in_timeout_pulse", xfer_err, 0);

    // usb_tx never starts: error after 4 cycles
    pkt(P_IN);
    chk("in_keep_toggle", tx_packet, T_D1);
    n = 0;
    while (n < 20 && !xfer_err) begin
      tick();
      n++;
    end
    chk("tx_rise_timeout", n, 5);
    chk("tx_rise_tx_release", tx_packet, T_NONE);

    // Reset in IN_ACK: outputs drop before the next edge, toggles clear
    pkt(P_IN);
    tx_complete();
    rst = 1'b1;
    #2;
    chk("async_reset_outputs", outs(), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pkt(P_IN);
    chk("in_after_reset_d0", tx_packet, T_D0);
    tx_complete();
    pkt(P_ACK);

    // IN with nothing loaded: NAK, back to IDLE, stray ACK ignored
    tx_data_valid = 1'b0;
    pkt(P_IN);
    chk("in_nak", tx_packet, T_NAK);
    tx_complete();
    pkt(P_ACK);
    chk("idle_ack_ignored", {tx_start, xfer_done, xfer_err}, 3'b000);

    // rx_error during OUT data packet
    pkt(P_OUT);
    rx_transfer_active = 1'b1;
    tick();
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    rx_transfer_active = 1'b0;
    chk("rxerr_xfer_err", xfer_err, 1);
    chk("rxerr_clear", clear, 1);
    chk("rxerr_no_tx", tx_start, 0);
    chk("rxerr_store_drop", rx_store_en, 0);

    // toggle_reset returns the OUT toggle to DATA0
    pkt(P_OUT);
    pkt(P_D0);
    tx_complete();
    toggle_reset = 1'b1;
    tick();
    toggle_reset = 1'b0;
    pkt(P_OUT);
    pkt(P_D0);
    chk("toggle_reset_done", xfer_done, 1);
    chk("toggle_reset_no_clear", clear, 0);
    tx_complete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
